branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage block directly downstream of the branch predictor and BTB.
- Compares each resolved branch's actual next PC against the prediction carried down the pipe with it (btb_hit, bp_pc).
- On a mismatch it redirects fetch, squashes wrong-path instructions, and drives the predictor's update inputs (update_pc, branch_target, branch_flush).
- Keeps saturating branch and mispredict counters for performance analysis.

Parameters:
- SHADOW_CYCLES, 2: number of ex_en advances after a redirect during which EX contents are wrong-path and ignored. Legal range 1..15.
- CNT_W, 32: width of the performance counters.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- ex_en  in  1  pipeline advance for the EX latch (ihit and no stall)
- ex_valid  in  1  EX holds a real instruction, not a bubble
- ex_branch  in  1  EX instruction is a conditional branch (beq/bne)
- ex_taken  in  1  branch condition evaluated true
- ex_pc  in  32  PC of the EX instruction (word_t)
- ex_target  in  32  computed branch target (word_t)
- ex_pred_hit  in  1  btb_hit captured at fetch of this instruction
- ex_pred_pc  in  32  bp_pc captured at fetch of this instruction
- redirect  out  1  fetch must load redirect_pc
- redirect_pc  out  32  corrected next PC
- squash  out  1  clear IF/ID and ID/EX latches
- update_pc  out  32  predictor update index (PC of the mispredicted branch)
- branch_target  out  32  correct next PC, written into the BTB entry
- branch_flush  out  1  one-cycle predictor update strobe
- branch_cnt  out  CNT_W  branches resolved
- mispred_cnt  out  CNT_W  mispredicts

Behaviour:
- Interface: one clock CLK. Reset nRST is asynchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, shadow counter 0. A reset mid-redirect abandons the redirect with no pulse.
- Resolve event: IDLE, ex_en=1, ex_valid=1, ex_branch=1 in the same cycle.
- actual = ex_taken ? ex_target : ex_pc+4.
- predicted = ex_pred_hit ? ex_pred_pc : ex_pc+4.
- All additions are 32-bit and wrap modulo 2^32.
- Mispredict when actual != predicted. The comparison covers all 32 bits.
- Latency: all outputs are registered. A mispredict in cycle N drives outputs from cycle N+1.
- branch_cnt increments on every resolve event. mispred_cnt increments on mispredict events.
- Both counters saturate at all-ones and never wrap.
- FSM state IDLE:
  - redirect=0, squash=0.
  - Mispredict goes to REDIRECT, latching redirect_pc=actual, update_pc=ex_pc, branch_target=actual.
  - A correct prediction stays in IDLE with no output change.
- FSM state REDIRECT:
  - redirect=1, squash=1.
  - branch_flush=1 only in the first cycle of REDIRECT, even if REDIRECT is held.
  - Holds while ex_en=0 so a stalled PC does not miss the redirect.
  - On ex_en=1 goes to SHADOW, loading the counter with SHADOW_CYCLES-1.
  - If SHADOW_CYCLES=1, goes directly to IDLE instead.
- FSM state SHADOW:
  - redirect=0, squash=0.
  - EX contents are ignored: no counting and no mispredict detection.
  - The counter decrements on each ex_en. At 0 with ex_en=1, goes to IDLE.
- redirect_pc, update_pc and branch_target hold their last value outside REDIRECT.
- Simultaneous events: a resolve event in the same cycle as a REDIRECT or SHADOW exit is ignored. That instruction is wrong-path by construction.
- Non-branch or ex_valid=0 instructions never change state or counters.
- ex_en=0 in IDLE: nothing is evaluated. The same instruction is evaluated when ex_en rises.

Decomposition:
- cpu_types_pkg: word_t; a new enum bru_state_t {IDLE, REDIRECT, SHADOW}; the constant PC_INCR = 32'd4.
- A branch_resolve_if interface joins this block and the predictor. It carries bru and bp modports and reuses the update_pc, branch_target and branch_flush names.
- One natural sub-module: sat_counter (parameter W; inc and nRST inputs; saturating), instantiated twice.

Test Plan:
- Reset with nRST=0 mid-REDIRECT -> all outputs 0 immediately (asynchronous); state IDLE after release.
- Correct not-taken: ex_pc=0x100, taken=0, hit=0 -> no redirect; branch_cnt=1, mispred_cnt=0.
- Mispredict taken: ex_pc=0x200, taken=1, target=0x240, hit=0 -> next cycle redirect=1, squash=1, branch_flush=1 for 1 cycle, redirect_pc=branch_target=0x240, update_pc=0x200, mispred_cnt=1.
- Wrong BTB target: hit=1, pred_pc=0x300, taken=0, ex_pc=0x400 -> redirect_pc=0x404. Then, with ex_en held low 3 cycles, redirect stays high, branch_flush is high 1 cycle only, and a branch in the shadow with SHADOW_CYCLES=2 is not counted.
- Wrap boundary: ex_pc=0xFFFFFFFC, taken=0, hit=1, pred_pc=0x0 -> no mispredict, since actual wraps to 0x0.
- Saturation: preload both counters to all-ones via force, then resolve a mispredict -> both remain 0xFFFFFFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, branch-resolve FSM states,
// and the sequential PC increment.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    SHADOW
  } bru_state_t;

  localparam word_t PC_INCR = 32'd4;

endpackage

// File: rtl/branch_resolve_if.sv
// Predictor update bundle between branch resolve and the
// branch predictor / BTB.
interface branch_resolve_if;
  import cpu_types_pkg::*;

  word_t update_pc;
  word_t branch_target;
  logic  branch_flush;

  modport bru (
    output update_pc,
    output branch_target,
    output branch_flush
  );

  modport bp (
    input update_pc,
    input branch_target,
    input branch_flush
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, never wraps.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: detects mispredicts, redirects
// fetch, squashes wrong-path work and updates the predictor.
module branch_resolve_unit
  import cpu_types_pkg::*;
#(
  parameter int SHADOW_CYCLES = 2,
  parameter int CNT_W         = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ex_en,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  word_t            ex_pc,
  input  word_t            ex_target,
  input  logic             ex_pred_hit,
  input  word_t            ex_pred_pc,
  output logic             redirect,
  output word_t            redirect_pc,
  output logic             squash,
  output word_t            update_pc,
  output word_t            branch_target,
  output logic             branch_flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [3:0] SHADOW_INIT =
    4'(SHADOW_CYCLES - 1);

  bru_state_t state_q;
  bru_state_t state_d;
  logic [3:0] shadow_q;
  logic [3:0] shadow_d;

  logic  redirect_q;
  logic  squash_q;
  logic  flush_q;
  word_t redirect_pc_q;
  word_t update_pc_q;
  word_t target_q;

  word_t pc_next;
  word_t actual;
  word_t predicted;
  logic  resolve;
  logic  mispred;

  branch_resolve_if bp_bus ();

  assign pc_next   = ex_pc + PC_INCR;
  assign actual    = ex_taken ? ex_target : pc_next;
  assign predicted = ex_pred_hit ? ex_pred_pc : pc_next;

  // Only IDLE evaluates EX; other states see wrong-path work.
  assign resolve = (state_q == IDLE) && ex_en
                && ex_valid && ex_branch;
  assign mispred = resolve && (actual != predicted);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (mispred) state_d = REDIRECT;
      end
      (state_q == REDIRECT): begin
        if (ex_en) begin
          if (SHADOW_CYCLES == 1) begin
            state_d = IDLE;
          end else begin
            state_d  = SHADOW;
            shadow_d = SHADOW_INIT;
          end
        end
      end
      (state_q == SHADOW): begin
        if (ex_en) begin
          if (shadow_q == 4'd0) state_d = IDLE;
          else shadow_d = shadow_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      redirect_q    <= 1'b0;
      squash_q      <= 1'b0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      update_pc_q   <= '0;
      target_q      <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      redirect_q <= (state_d == REDIRECT);
      squash_q   <= (state_d == REDIRECT);
      flush_q    <= (state_d == REDIRECT)
                 && (state_q != REDIRECT);
      if (mispred) begin
        redirect_pc_q <= actual;
        update_pc_q   <= ex_pc;
        target_q      <= actual;
      end
    end
  end

  assign bp_bus.update_pc     = update_pc_q;
  assign bp_bus.branch_target = target_q;
  assign bp_bus.branch_flush  = flush_q;

  assign redirect      = redirect_q;
  assign squash        = squash_q;
  assign redirect_pc   = redirect_pc_q;
  assign update_pc     = bp_bus.update_pc;
  assign branch_target = bp_bus.branch_target;
  assign branch_flush  = bp_bus.branch_flush;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (resolve),
    .cnt  (branch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mispred_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (mispred),
    .cnt  (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with an expected-
// output scoreboard checked after every clock.
module tb_branch_resolve_unit;

  logic        CLK;
  logic        nRST;
  logic        ex_en;
  logic        ex_valid;
  logic        ex_branch;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_hit;
  logic [31:0] ex_pred_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        squash;
  logic [31:0] update_pc;
  logic [31:0] branch_target;
  logic        branch_flush;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int n_assert;
  int n_fail;

  typedef struct {
    string       tag;
    logic        rd;
    logic        sq;
    logic        fl;
    logic [31:0] rpc;
    logic [31:0] upc;
    logic [31:0] bt;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];

  branch_resolve_unit #(
    .SHADOW_CYCLES (2),
    .CNT_W         (32)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ex_en         (ex_en),
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_taken      (ex_taken),
    .ex_pc         (ex_pc),
    .ex_target     (ex_target),
    .ex_pred_hit   (ex_pred_hit),
    .ex_pred_pc    (ex_pred_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .squash        (squash),
    .update_pc     (update_pc),
    .branch_target (branch_target),
    .branch_flush  (branch_flush),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cmp(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input string tag,
                      input logic rd, input logic sq,
                      input logic fl,
                      input logic [31:0] rpc,
                      input logic [31:0] upc,
                      input logic [31:0] bt,
                      input logic [31:0] bc,
                      input logic [31:0] mc);
    exp_t e;
    e.tag = tag; e.rd = rd; e.sq = sq; e.fl = fl;
    e.rpc = rpc; e.upc = upc; e.bt = bt;
    e.bc = bc; e.mc = mc;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: observed empty expected entry");
      return;
    end
    e = sb.pop_front();
    cmp({e.tag, ".redirect"}, {31'b0, redirect}, {31'b0, e.rd});
    cmp({e.tag, ".squash"}, {31'b0, squash}, {31'b0, e.sq});
    cmp({e.tag, ".flush"}, {31'b0, branch_flush}, {31'b0, e.fl});
    cmp({e.tag, ".redirect_pc"}, redirect_pc, e.rpc);
    cmp({e.tag, ".update_pc"}, update_pc, e.upc);
    cmp({e.tag, ".branch_target"}, branch_target, e.bt);
    cmp({e.tag, ".branch_cnt"}, branch_cnt, e.bc);
    cmp({e.tag, ".mispred_cnt"}, mispred_cnt, e.mc);
  endtask

  task automatic drive(input logic en, input logic vld,
                       input logic br, input logic tk,
                       input logic [31:0] pc,
                       input logic [31:0] tgt,
                       input logic hit,
                       input logic [31:0] ppc);
    ex_en = en; ex_valid = vld; ex_branch = br;
    ex_taken = tk; ex_pc = pc; ex_target = tgt;
    ex_pred_hit = hit; ex_pred_pc = ppc;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    check_out();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    nRST     = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    push("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check_out();
    #1 nRST = 1'b1;

    // correct not-taken, no BTB hit
    drive(1, 1, 1, 0, 32'h100, 32'h180, 0, 32'h0);
    push("nt_ok", 0, 0, 0, 0, 0, 0, 1, 0);
    tick();

    // stalled EX and non-branch are not evaluated
    drive(0, 1, 1, 1, 32'h900, 32'h999, 0, 32'h0);
    push("stall", 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 1, 0, 1, 32'h900, 32'h999, 0, 32'h0);
    push("nonbr", 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 0, 1, 1, 32'h900, 32'h999, 0, 32'h0);
    push("bubble", 0, 0, 0, 0, 0, 0, 1, 0);
    tick();

    // taken branch, no prediction
    drive(1, 1, 1, 1, 32'h200, 32'h240, 0, 32'h0);
    push("mp_tk", 1, 1, 1, 32'h240, 32'h200, 32'h240, 2, 1);
    tick();
    drive(1, 1, 1, 1, 32'h500, 32'h600, 0, 32'h0);
    push("rd_exit", 0, 0, 0, 32'h240, 32'h200, 32'h240, 2, 1);
    tick();
    push("shadow1", 0, 0, 0, 32'h240, 32'h200, 32'h240, 2, 1);
    tick();
    push("shadow0", 0, 0, 0, 32'h240, 32'h200, 32'h240, 2, 1);
    tick();

    // BTB hit with stale target, then stalled redirect
    drive(1, 1, 1, 0, 32'h400, 32'h480, 1, 32'h300);
    push("btb_bad", 1, 1, 1, 32'h404, 32'h400, 32'h404, 3, 2);
    tick();
    drive(0, 1, 1, 1, 32'h500, 32'h600, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      push("rd_hold", 1, 1, 0, 32'h404, 32'h400, 32'h404, 3, 2);
      tick();
    end
    drive(1, 1, 1, 1, 32'h500, 32'h600, 0, 32'h0);
    push("rd_exit2", 0, 0, 0, 32'h404, 32'h400, 32'h404, 3, 2);
    tick();
    push("sh_br", 0, 0, 0, 32'h404, 32'h400, 32'h404, 3, 2);
    tick();
    drive(0, 1, 1, 1, 32'h500, 32'h600, 0, 32'h0);
    push("sh_stall", 0, 0, 0, 32'h404, 32'h400, 32'h404, 3, 2);
    tick();
    drive(1, 1, 1, 1, 32'h500, 32'h600, 0, 32'h0);
    push("sh_exit", 0, 0, 0, 32'h404, 32'h400, 32'h404, 3, 2);
    tick();

    // sequential PC wraps to zero and matches prediction
    drive(1, 1, 1, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h0);
    push("wrap", 0, 0, 0, 32'h404, 32'h400, 32'h404, 4, 2);
    tick();
    drive(1, 1, 1, 1, 32'h800, 32'h840, 1, 32'h840);
    push("tk_ok", 0, 0, 0, 32'h404, 32'h400, 32'h404, 5, 2);
    tick();
    // mismatch only in bit 31
    drive(1, 1, 1, 1, 32'h800, 32'h840, 1, 32'h8000_0840);
    push("msb", 1, 1, 1, 32'h840, 32'h800, 32'h840, 6, 3);
    tick();

    // asynchronous reset while redirecting
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    #2 nRST = 1'b0;
    #1;
    push("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    check_out();
    push("rst_held", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    nRST = 1'b1;
    push("rst_rel", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 0, 32'h100, 32'h180, 0, 32'h0);
    push("post_rst", 0, 0, 0, 0, 0, 0, 1, 0);
    tick();

    // saturation from all-ones
    force dut.u_branch_cnt.cnt = 32'hFFFF_FFFF;
    force dut.u_mispred_cnt.cnt = 32'hFFFF_FFFF;
    #1;
    release dut.u_branch_cnt.cnt;
    release dut.u_mispred_cnt.cnt;
    drive(1, 1, 1, 1, 32'h200, 32'h240, 0, 32'h0);
    push("sat", 1, 1, 1, 32'h240, 32'h200, 32'h240,
         32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    push("sat_hold", 1, 1, 0, 32'h240, 32'h200, 32'h240,
         32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
